ccip_c0_rd_arb: RTL and testbench
=================================

Name: ccip_c0_rd_arb

Overview:
- Shares the CCI-P c0 (read-request) channel between two requesters: requester 0 is the DMA engine and requester 1 is the application's direct-read port.
- Sits between those requesters and the MPF afu-side c0 channel.
- Arbitrates round-robin, honours c0TxAlmFull, limits outstanding lines per requester, and tags Mdata so read responses are steered back to the issuing requester.
- Provides a quiesce/idle handshake so software and the app can drain reads before a soft reset or reconfiguration.

Parameters:
- MAX_OUTSTANDING, 128, maximum in-flight read lines per requester (power of two, at least 4).
- TAG_BIT, 15, Mdata bit used as source tag; requesters must drive it 0.
- CNT_W, $clog2(MAX_OUTSTANDING)+1, width of the outstanding-line counters.

Ports:
- clk  in  1  AFU clock (CCI-P clock domain).
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 (DMA) read request valid.
- req0_hdr  in  t_ccip_c0_ReqMemHdr  requester 0 read header.
- req0_ready  out  1  requester 0 accepted this cycle when valid && ready.
- req1_valid  in  1  requester 1 (app) read request valid.
- req1_hdr  in  t_ccip_c0_ReqMemHdr  requester 1 read header.
- req1_ready  out  1  requester 1 accept.
- c0Tx  out  t_if_ccip_c0_Tx  registered request to the MPF afu-side c0.
- c0TxAlmFull  in  1  almost-full from MPF.
- c0Rx  in  t_if_ccip_c0_Rx  read responses from MPF.
- rsp0_c0Rx  out  t_if_ccip_c0_Rx  responses routed to requester 0.
- rsp1_c0Rx  out  t_if_ccip_c0_Rx  responses routed to requester 1.
- quiesce  in  1  level; block new grants while high.
- idle  out  1  quiesce high and both counters zero.
- outstanding0  out  CNT_W  in-flight lines for requester 0.
- outstanding1  out  CNT_W  in-flight lines for requester 1.
- tag_err  out  1  sticky: a response arrived for a requester whose counter was zero.

Behaviour:
- Line count of a request: len = cl_len + 1 (1, 2 or 4 lines).
- Eligibility: eligible_i = req_i_valid && !reset && !c0TxAlmFull && !quiesce && (outstanding_i + len_i <= MAX_OUTSTANDING).
- Grant is combinational and round-robin via a 1-bit last-grant pointer (reset value 1, so requester 0 wins first):
  - If both requesters are eligible, grant the one not granted last.
  - If only one is eligible, grant it.
- req_i_ready equals grant_i; at most one ready is high per cycle.
- Issue latency: an accept in cycle N drives c0Tx.valid=1 in cycle N+1. The header is copied unchanged except mdata[TAG_BIT]=source id. c0Tx.valid is 0 in any cycle with no accept.
- A request that is not granted is held by the requester (valid/ready); the arbiter never drops it.
- Response routing:
  - Applies when c0Rx.rspValid=1 and resp_type=eRSP_RDLINE.
  - Route by mdata[TAG_BIT]. Drive rsp<tag>_c0Rx.rspValid=1 in cycle N+1 with hdr and data copied and mdata[TAG_BIT] cleared to 0. The other port's rspValid is 0.
  - Each response beat decrements the matching counter by 1.
  - If that counter is already 0: no decrement, set tag_err, and still forward the beat.
- Non-RDLINE responses and mmioRdValid/mmioWrValid are not forwarded; all valid bits on both rsp ports are 0.
- Counters:
  - Same-cycle issue (+len) and response (-1) on one requester apply as a net update, with no lost update.
  - Counters never exceed MAX_OUTSTANDING and never wrap below 0.
- Quiesce: new grants stop in the cycle quiesce rises. An accept already registered still issues in the next cycle. idle = quiesce && outstanding0==0 && outstanding1==0, registered (1-cycle lag).
- Reset values: c0Tx.valid=0, rsp*.rspValid=0, outstanding*=0, idle=0, tag_err=0, last-grant=1.
- Reset mid-operation: counters are cleared and in-flight tags are forgotten. Responses arriving while reset is high are discarded and do not set tag_err.

Decomposition:
- Package ccip_c0_rd_arb_pkg:
  - typedef t_arb_src (1-bit source id).
  - function for line count from t_ccip_clLen.
  - constant ARB_NUM_REQ=2.
- Sub-module ccip_c0_rd_arb_credit: one outstanding-line counter with inc-by-len, dec-by-1, zero/overflow checks and the error pulse. Instantiated twice.

Test Plan:
- Both requesters valid continuously with cl_len=1-line, no almfull -> grants alternate 0,1,0,1. c0Tx.valid every cycle from cycle 1. mdata[15] alternates 0/1.
- Requester 0 issues four 4-line reads with MAX_OUTSTANDING=16 and no responses -> outstanding0=16, and a 5th request is held with req0_ready=0. One response beat -> outstanding0=15, still blocked (15+4>16). Four beats -> 12, accepted.
- Response with mdata=0x8005 -> rsp1 rspValid one cycle later with mdata=0x0005; outstanding1 decremented; rsp0 silent.
- c0TxAlmFull=1 for 10 cycles with both valid -> no readies and no c0Tx.valid. Release -> requester 0 granted first after reset.
- Issue 3 lines, raise quiesce -> no new grants. idle=0 until the 3rd response, then idle=1 one cycle later.
- RDLINE response tagged 0 with outstanding0=0 -> tag_err=1 and sticky. Pulse reset -> tag_err=0 and counters 0.

Source files
------------

// File: rtl/ccip_c0_rd_arb_pkg.sv
// Shared types for the c0 read-request arbiter: a minimal CCI-P c0 slice
// (request/response headers and channel bundles) plus arbiter helpers.
package ccip_c0_rd_arb_pkg;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h4,
        eREQ_RDLINE_S = 4'h5
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef logic [15:0]  t_ccip_mdata;
    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [511:0] t_ccip_clData;

    typedef struct packed {
        logic [1:0]   vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [1:0]   vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    localparam int ARB_NUM_REQ = 2;

    // Requester id carried in the Mdata tag bit.
    typedef logic t_arb_src;

    // Lines moved by one request: cl_len + 1 (1, 2 or 4 for legal encodings).
    function automatic logic [2:0] lineCount(input t_ccip_clLen clLen);
        return {1'b0, clLen} + 3'd1;
    endfunction

endpackage

// File: rtl/ccip_c0_rd_arb_credit.sv
// Outstanding-line counter for one requester: +len on issue, -1 per response
// beat, net update when both happen together, never below 0 or above the cap.
module ccip_c0_rd_arb_credit
    import ccip_c0_rd_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 128,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       reqLen,
    input  logic             incValid,
    input  logic             decValid,
    output logic [CNT_W-1:0] count,
    output logic             fits,
    output logic             decErr
);

    localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAX_OUTSTANDING);

    logic [CNT_W:0] withReq;
    logic [CNT_W:0] nxt;
    logic           decOk;

    // Headroom check for the pending request and next-count arithmetic.
    always_comb begin
        withReq = {1'b0, count} + (CNT_W+1)'(reqLen);
        fits    = (withReq <= MAX_CNT);
        decOk   = decValid && (count != '0);
        decErr  = decValid && (count == '0);
        nxt     = {1'b0, count};
        if (incValid) nxt = nxt + (CNT_W+1)'(reqLen);
        if (decOk)    nxt = nxt - (CNT_W+1)'(1);
        if (nxt > MAX_CNT) nxt = MAX_CNT;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else       count <= nxt[CNT_W-1:0];
    end

endmodule

// File: rtl/ccip_c0_rd_arb.sv
// Two-way round-robin arbiter for the CCI-P c0 read-request channel.
// Requester 0 is the DMA engine, requester 1 the app's direct-read port.
// The source id rides in Mdata[TAG_BIT] so responses can be steered back.
module ccip_c0_rd_arb
    import ccip_c0_rd_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 128,
    parameter int TAG_BIT         = 15,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  t_ccip_c0_ReqMemHdr req0_hdr,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  t_ccip_c0_ReqMemHdr req1_hdr,
    output logic               req1_ready,
    output t_if_ccip_c0_Tx     c0Tx,
    input  logic               c0TxAlmFull,
    input  t_if_ccip_c0_Rx     c0Rx,
    output t_if_ccip_c0_Rx     rsp0_c0Rx,
    output t_if_ccip_c0_Rx     rsp1_c0Rx,
    input  logic               quiesce,
    output logic               idle,
    output logic [CNT_W-1:0]   outstanding0,
    output logic [CNT_W-1:0]   outstanding1,
    output logic               tag_err
);

    logic [2:0]         len0, len1;
    logic               fits0, fits1;
    logic               elig0, elig1;
    logic               grant0, grant1;
    logic               accept;
    t_arb_src           grantSrc;
    t_arb_src           lastGrant;
    t_ccip_c0_ReqMemHdr issueHdr;
    logic               rspFwd, rspTag;
    logic               dec0, dec1;
    logic               err0, err1;
    t_if_ccip_c0_Rx     rspClean;

    assign len0 = lineCount(req0_hdr.cl_len);
    assign len1 = lineCount(req1_hdr.cl_len);

    ccip_c0_rd_arb_credit #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CNT_W          (CNT_W)
    ) credit0 (
        .clk     (clk),
        .reset   (reset),
        .reqLen  (len0),
        .incValid(grant0),
        .decValid(dec0),
        .count   (outstanding0),
        .fits    (fits0),
        .decErr  (err0)
    );

    ccip_c0_rd_arb_credit #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CNT_W          (CNT_W)
    ) credit1 (
        .clk     (clk),
        .reset   (reset),
        .reqLen  (len1),
        .incValid(grant1),
        .decValid(dec1),
        .count   (outstanding1),
        .fits    (fits1),
        .decErr  (err1)
    );

    // Eligibility and round-robin grant; the side not granted last wins a tie.
    always_comb begin
        elig0  = req0_valid && !reset && !c0TxAlmFull && !quiesce && fits0;
        elig1  = req1_valid && !reset && !c0TxAlmFull && !quiesce && fits1;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            grant0 = (lastGrant == 1'b1);
            grant1 = (lastGrant == 1'b0);
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
        accept   = grant0 || grant1;
        grantSrc = grant1;
        issueHdr = grantSrc ? req1_hdr : req0_hdr;
        issueHdr.mdata[TAG_BIT] = grantSrc;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Response steering: only RDLINE beats are forwarded, tag bit stripped.
    always_comb begin
        rspFwd = c0Rx.rspValid && (c0Rx.hdr.resp_type == eRSP_RDLINE) &&
                 !c0Rx.mmioRdValid && !c0Rx.mmioWrValid;
        rspTag = c0Rx.hdr.mdata[TAG_BIT];
        dec0   = rspFwd && !rspTag;
        dec1   = rspFwd && rspTag;
        rspClean                    = c0Rx;
        rspClean.hdr.mdata[TAG_BIT] = 1'b0;
        rspClean.rspValid           = 1'b0;
        rspClean.mmioRdValid        = 1'b0;
        rspClean.mmioWrValid        = 1'b0;
    end

    // Registered request issue toward MPF.
    always_ff @(posedge clk) begin
        if (reset) begin
            c0Tx <= '0;
        end else begin
            c0Tx.valid <= accept;
            c0Tx.hdr   <= issueHdr;
        end
    end

    // Registered response delivery to the owning requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_c0Rx <= '0;
            rsp1_c0Rx <= '0;
        end else begin
            rsp0_c0Rx          <= rspClean;
            rsp0_c0Rx.rspValid <= dec0;
            rsp1_c0Rx          <= rspClean;
            rsp1_c0Rx.rspValid <= dec1;
        end
    end

    // Round-robin pointer; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset)       lastGrant <= 1'b1;
        else if (accept) lastGrant <= grantSrc;
    end

    // Sticky flag for a response that arrived with no matching credit.
    always_ff @(posedge clk) begin
        if (reset)            tag_err <= 1'b0;
        else if (err0 || err1) tag_err <= 1'b1;
    end

    // Drain indicator, one cycle behind the counters.
    always_ff @(posedge clk) begin
        if (reset) idle <= 1'b0;
        else       idle <= quiesce && (outstanding0 == '0) && (outstanding1 == '0);
    end

endmodule

// File: tb/tb_ccip_c0_rd_arb.sv
// Directed bench for ccip_c0_rd_arb with a 16-line credit cap.
module tb_ccip_c0_rd_arb;
    import ccip_c0_rd_arb_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               req0_valid, req1_valid;
    t_ccip_c0_ReqMemHdr req0_hdr, req1_hdr;
    logic               req0_ready, req1_ready;
    t_if_ccip_c0_Tx     c0Tx;
    logic               c0TxAlmFull;
    t_if_ccip_c0_Rx     c0Rx;
    t_if_ccip_c0_Rx     rsp0_c0Rx, rsp1_c0Rx;
    logic               quiesce;
    logic               idle;
    logic [4:0]         outstanding0, outstanding1;
    logic               tag_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ccip_c0_rd_arb #(.MAX_OUTSTANDING(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_hdr    (req0_hdr),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_hdr    (req1_hdr),
        .req1_ready  (req1_ready),
        .c0Tx        (c0Tx),
        .c0TxAlmFull (c0TxAlmFull),
        .c0Rx        (c0Rx),
        .rsp0_c0Rx   (rsp0_c0Rx),
        .rsp1_c0Rx   (rsp1_c0Rx),
        .quiesce     (quiesce),
        .idle        (idle),
        .outstanding0(outstanding0),
        .outstanding1(outstanding1),
        .tag_err     (tag_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One response beat presented for one cycle.
    task automatic sendRsp(input logic tag, input logic [14:0] low, input t_ccip_c0_rsp rt);
        c0Rx = '0;
        c0Rx.hdr.resp_type = rt;
        c0Rx.hdr.mdata     = {tag, low};
        c0Rx.data          = {496'd0, 1'b0, low};
        c0Rx.rspValid      = 1'b1;
        tick();
        c0Rx.rspValid = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        req0_hdr    = '0;
        req1_hdr    = '0;
        c0TxAlmFull = 1'b0;
        c0Rx        = '0;
        quiesce     = 1'b0;
        tick(); tick(); tick();

        chk("rst_tx_valid", c0Tx.valid, 1'b0);
        chk("rst_rsp0", rsp0_c0Rx.rspValid, 1'b0);
        chk("rst_rsp1", rsp1_c0Rx.rspValid, 1'b0);
        chk("rst_out0", outstanding0, 5'd0);
        chk("rst_out1", outstanding1, 5'd0);
        chk("rst_idle", idle, 1'b0);
        chk("rst_tagerr", tag_err, 1'b0);
        reset = 1'b0;

        // Round-robin with both requesters always valid, 1-line reads.
        req0_hdr.cl_len   = eCL_LEN_1;
        req0_hdr.req_type = eREQ_RDLINE_I;
        req0_hdr.mdata    = 16'h0011;
        req1_hdr.cl_len   = eCL_LEN_1;
        req1_hdr.req_type = eREQ_RDLINE_I;
        req1_hdr.mdata    = 16'h0022;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_ready0", req0_ready, (i % 2) == 0);
            chk("rr_ready1", req1_ready, (i % 2) == 1);
            tick();
            chk("rr_tx_valid", c0Tx.valid, 1'b1);
            chk("rr_tx_mdata", c0Tx.hdr.mdata, ((i % 2) == 0) ? 16'h0011 : 16'h8022);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_out0", outstanding0, 5'd2);
        chk("rr_out1", outstanding1, 5'd2);
        tick();
        chk("rr_tx_idle", c0Tx.valid, 1'b0);

        // Tag-1 response steering.
        sendRsp(1'b1, 15'h0005, eRSP_RDLINE);
        chk("rt_rsp1_valid", rsp1_c0Rx.rspValid, 1'b1);
        chk("rt_rsp1_mdata", rsp1_c0Rx.hdr.mdata, 16'h0005);
        chk("rt_rsp1_data", rsp1_c0Rx.data[15:0], 16'h0005);
        chk("rt_rsp0_quiet", rsp0_c0Rx.rspValid, 1'b0);
        chk("rt_out1", outstanding1, 5'd1);
        chk("rt_out0", outstanding0, 5'd2);
        sendRsp(1'b1, 15'h0022, eRSP_RDLINE);
        sendRsp(1'b0, 15'h0011, eRSP_RDLINE);
        chk("rt_rsp0_valid", rsp0_c0Rx.rspValid, 1'b1);
        chk("rt_rsp1_quiet", rsp1_c0Rx.rspValid, 1'b0);
        sendRsp(1'b0, 15'h0011, eRSP_RDLINE);
        chk("rt_drain0", outstanding0, 5'd0);
        chk("rt_drain1", outstanding1, 5'd0);
        chk("rt_no_err", tag_err, 1'b0);

        // Credit limit: four 4-line reads fill the 16-line budget.
        req0_hdr.cl_len = eCL_LEN_4;
        req0_hdr.mdata  = 16'h0100;
        req0_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("cr_ready", req0_ready, 1'b1);
            tick();
        end
        chk("cr_full", outstanding0, 5'd16);
        chk("cr_blocked", req0_ready, 1'b0);
        tick();
        chk("cr_no_tx", c0Tx.valid, 1'b0);
        sendRsp(1'b0, 15'h0100, eRSP_RDLINE);
        chk("cr_out15", outstanding0, 5'd15);
        chk("cr_still_blocked", req0_ready, 1'b0);
        for (int i = 0; i < 3; i++) sendRsp(1'b0, 15'h0100, eRSP_RDLINE);
        chk("cr_out12", outstanding0, 5'd12);
        chk("cr_unblocked", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        chk("cr_refill", outstanding0, 5'd16);
        chk("cr_tx_valid", c0Tx.valid, 1'b1);
        chk("cr_tx_mdata", c0Tx.hdr.mdata, 16'h0100);

        // Reset mid-operation clears the counters.
        reset = 1'b1;
        tick(); tick();
        chk("mr_out0", outstanding0, 5'd0);
        chk("mr_tx", c0Tx.valid, 1'b0);
        reset = 1'b0;

        // Almost-full blocks everything; requester 0 wins first afterwards.
        req0_hdr.cl_len = eCL_LEN_1;
        req0_hdr.mdata  = 16'h0001;
        req1_hdr.mdata  = 16'h0002;
        c0TxAlmFull = 1'b1;
        req0_valid  = 1'b1;
        req1_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("af_ready0", req0_ready, 1'b0);
            chk("af_ready1", req1_ready, 1'b0);
            chk("af_tx", c0Tx.valid, 1'b0);
            tick();
        end
        c0TxAlmFull = 1'b0;
        #1;
        chk("af_first0", req0_ready, 1'b1);
        chk("af_first1", req1_ready, 1'b0);
        tick();
        chk("af_tx_mdata0", c0Tx.hdr.mdata, 16'h0001);
        chk("af_next1", req1_ready, 1'b1);
        tick();
        chk("af_tx_mdata1", c0Tx.hdr.mdata, 16'h8002);
        chk("af_next0", req0_ready, 1'b1);
        tick();
        chk("q_out0", outstanding0, 5'd2);
        chk("q_out1", outstanding1, 5'd1);

        // Quiesce: grants stop at once, idle follows the last response.
        quiesce = 1'b1;
        #1;
        chk("q_ready0", req0_ready, 1'b0);
        chk("q_ready1", req1_ready, 1'b0);
        chk("q_last_issue", c0Tx.valid, 1'b1);
        tick();
        chk("q_no_tx", c0Tx.valid, 1'b0);
        chk("q_idle0", idle, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        sendRsp(1'b0, 15'h0001, eRSP_RDLINE);
        sendRsp(1'b1, 15'h0002, eRSP_RDLINE);
        chk("q_idle_pending", idle, 1'b0);
        sendRsp(1'b0, 15'h0001, eRSP_RDLINE);
        chk("q_drained", outstanding0 + outstanding1, 0);
        chk("q_idle_lag", idle, 1'b0);
        tick();
        chk("q_idle", idle, 1'b1);
        quiesce = 1'b0;
        tick();
        chk("q_idle_off", idle, 1'b0);

        // Response with no credit: forwarded, flagged, counter stays 0.
        sendRsp(1'b0, 15'h0007, eRSP_RDLINE);
        chk("te_flag", tag_err, 1'b1);
        chk("te_fwd", rsp0_c0Rx.rspValid, 1'b1);
        chk("te_mdata", rsp0_c0Rx.hdr.mdata, 16'h0007);
        chk("te_out0", outstanding0, 5'd0);
        tick();
        chk("te_sticky", tag_err, 1'b1);
        chk("te_rsp0_off", rsp0_c0Rx.rspValid, 1'b0);

        // Non-RDLINE and MMIO traffic is not forwarded.
        sendRsp(1'b1, 15'h0003, eRSP_UMSG);
        chk("nf_umsg1", rsp1_c0Rx.rspValid, 1'b0);
        chk("nf_umsg0", rsp0_c0Rx.rspValid, 1'b0);
        c0Rx = '0;
        c0Rx.mmioRdValid = 1'b1;
        tick();
        c0Rx = '0;
        chk("nf_mmio", rsp0_c0Rx.mmioRdValid | rsp1_c0Rx.mmioRdValid |
                       rsp0_c0Rx.rspValid | rsp1_c0Rx.rspValid, 1'b0);

        // Responses during reset are dropped without flagging.
        reset = 1'b1;
        c0Rx.hdr.resp_type = eRSP_RDLINE;
        c0Rx.hdr.mdata     = 16'h8009;
        c0Rx.rspValid      = 1'b1;
        tick(); tick();
        reset = 1'b0;
        c0Rx  = '0;
        chk("rr_tagerr_clr", tag_err, 1'b0);
        chk("rr_out1", outstanding1, 5'd0);
        chk("rr_rsp1", rsp1_c0Rx.rspValid, 1'b0);
        tick();
        chk("rr_tagerr_stay", tag_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
